// File: rtl/latch_exerciser_pkg.sv
// Shared constants for the gated D latch exerciser: FSM encoding, step sizing,
// and the bit layout of a stimulus/expect vector.
package latch_exerciser_pkg;

  localparam int NUM_STEPS = 12;
  localparam int STEP_W    = 4;
  localparam int VEC_W     = 5;

  localparam logic [STEP_W-1:0] FAIL_NONE = 4'hF;

  // Vector layout {set_n, reset_n, d, g, exp_q}
  localparam int BIT_SET_N   = 4;
  localparam int BIT_RESET_N = 3;
  localparam int BIT_D       = 2;
  localparam int BIT_G       = 1;
  localparam int BIT_EXP_Q   = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_APPLY  = 3'd1;
  localparam state_t ST_HOLD   = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // Vector driven when idle or for out-of-range addresses: latch inputs inactive.
  localparam logic [VEC_W-1:0] SAFE_VEC = 5'b11000;

endpackage

// File: rtl/latch_vec_rom.sv
// Fixed stimulus/expect table for the latch exerciser; pure combinational lookup.
module latch_vec_rom
  import latch_exerciser_pkg::*;
(
  input  logic [STEP_W-1:0] addr,
  output logic [VEC_W-1:0]  vec
);

  always_comb begin
    vec = SAFE_VEC;
    case (addr)
      4'd0:    vec = 5'b01001;  // async set
      4'd1:    vec = 5'b11101;  // d changes with gate closed: q holds 1
      4'd2:    vec = 5'b10000;  // async reset
      4'd3:    vec = 5'b10100;
      4'd4:    vec = 5'b11000;
      4'd5:    vec = 5'b11100;
      4'd6:    vec = 5'b11010;  // transparent transfers from here
      4'd7:    vec = 5'b11111;
      4'd8:    vec = 5'b11010;
      4'd9:    vec = 5'b11111;
      4'd10:   vec = 5'b11010;
      4'd11:   vec = 5'b11000;
      default: vec = SAFE_VEC;
    endcase
  end

endmodule

// File: rtl/latch_exerciser.sv
// Stimulus/check engine for a gated D latch with async set/reset. Steps the ROM
// table, holds each vector HOLD_CYCLES+1 clocks, checks synchronized q.
// Define LATCH_EXERCISER_QN_CHECK_EN to also check q_n against ~exp_q.
module latch_exerciser
  import latch_exerciser_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              dut_set_n,
  output logic              dut_reset_n,
  output logic              dut_d,
  output logic              dut_g,
  input  logic              dut_q,
  input  logic              dut_q_n,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [3:0]        err_count,
  output logic [STEP_W-1:0] fail_step
);

  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [3:0]          hold_cnt;
  logic [VEC_W-1:0]    rom_vec;
  logic [1:0]          q_sync;
  logic                mismatch;

  latch_vec_rom u_rom (
    .addr (step),
    .vec  (rom_vec)
  );

  // q is asynchronous to clk; two flops before it is ever compared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_sync <= 2'b00;
    else          q_sync <= {q_sync[0], dut_q};
  end

`ifdef LATCH_EXERCISER_QN_CHECK_EN
  logic [1:0] qn_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) qn_sync <= 2'b00;
    else          qn_sync <= {qn_sync[0], dut_q_n};
  end

  // Either rail wrong counts as a single error for the step.
  assign mismatch = (q_sync[1] != rom_vec[BIT_EXP_Q]) ||
                    (qn_sync[1] != ~rom_vec[BIT_EXP_Q]);
`else
  logic unused_q_n;
  assign unused_q_n = dut_q_n;
  assign mismatch   = (q_sync[1] != rom_vec[BIT_EXP_Q]);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      step        <= '0;
      hold_cnt    <= '0;
      dut_set_n   <= 1'b1;
      dut_reset_n <= 1'b1;
      dut_d       <= 1'b0;
      dut_g       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_count   <= '0;
      fail_step   <= FAIL_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count <= '0;
            fail_step <= FAIL_NONE;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            step      <= '0;
            state     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          dut_set_n   <= rom_vec[BIT_SET_N];
          dut_reset_n <= rom_vec[BIT_RESET_N];
          dut_d       <= rom_vec[BIT_D];
          dut_g       <= rom_vec[BIT_G];
          hold_cnt    <= 4'd1;
          state       <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) state    <= ST_CHECK;
          else                       hold_cnt <= hold_cnt + 4'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != 4'hF)     err_count <= err_count + 4'd1;
            if (fail_step == FAIL_NONE) fail_step <= step;
          end
          if (step == LAST_STEP) begin
            state <= ST_FINISH;
          end else begin
            step  <= step + 1'b1;
            state <= ST_APPLY;
          end
        end
        ST_FINISH: begin
          // err_count already includes the last step's result here.
          dut_set_n   <= 1'b1;
          dut_reset_n <= 1'b1;
          dut_d       <= 1'b0;
          dut_g       <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          pass        <= (err_count == 4'd0);
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_exerciser.sv
// Scoreboard bench: behavioural latch (with fault modes) on the exerciser's
// pins; expected run results predicted from the vector table and pushed at start.
module tb_latch_exerciser;
  import latch_exerciser_pkg::*;

  localparam int HOLD    = 4;
  localparam int STEP_LEN = HOLD + 1;
  localparam int RUN_LEN = NUM_STEPS * STEP_LEN + 1;

  typedef enum int {M_GOOD, M_TIE0, M_TIE1, M_GIGN, M_FLIP} mode_t;

  typedef struct {
    int err;
    int fs;
    int pass;
    int start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic dut_set_n, dut_reset_n, dut_d, dut_g;
  logic dut_q, dut_q_n;
  logic busy, done, pass;
  logic [3:0] err_count, fail_step;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int run_start = -1000;
  exp_t sb[$];

  mode_t       mode = M_GOOD;
  logic [11:0] mask = '0;
  bit          qn_tie0 = 1'b0;

  // Stimulus table as written in the block description: {set_n, reset_n, d, g, exp_q}
  logic [4:0] tbl [NUM_STEPS] = '{5'b01001, 5'b11101, 5'b10000, 5'b10100,
                                  5'b11000, 5'b11100, 5'b11010, 5'b11111,
                                  5'b11010, 5'b11111, 5'b11010, 5'b11000};

  latch_exerciser #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .dut_set_n   (dut_set_n),
    .dut_reset_n (dut_reset_n),
    .dut_d       (dut_d),
    .dut_g       (dut_g),
    .dut_q       (dut_q),
    .dut_q_n     (dut_q_n),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_count   (err_count),
    .fail_step   (fail_step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural latch under test; M_GIGN models a broken gate.
  logic lq;
  always_latch begin
    if (!dut_set_n)                      lq <= 1'b1;
    else if (!dut_reset_n)               lq <= 1'b0;
    else if (dut_g && (mode != M_GIGN))  lq <= dut_d;
  end

  int   rel;
  logic flip, qo;
  always_comb begin
    rel  = cyc - run_start;
    flip = 1'b0;
    if (mode == M_FLIP && rel >= 0 && rel < NUM_STEPS * STEP_LEN)
      flip = mask[rel / STEP_LEN];
    case (mode)
      M_TIE0:  qo = 1'b0;
      M_TIE1:  qo = 1'b1;
      default: qo = lq ^ flip;
    endcase
    dut_q   = qo;
    dut_q_n = qn_tie0 ? 1'b0 : ~qo;
  end

  function automatic exp_t predict(mode_t m, logic [11:0] msk, bit qn0);
    exp_t e;
    bit q, obs, qn, bad;
    logic [4:0] v;
    q = 1'b0;
    e.err = 0;
    e.fs = 15;
    e.start_cyc = 0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      v = tbl[k];
      if (!v[4])                      q = 1'b1;
      else if (!v[3])                 q = 1'b0;
      else if (v[1] && m != M_GIGN)   q = v[2];
      if (m == M_TIE0)      obs = 1'b0;
      else if (m == M_TIE1) obs = 1'b1;
      else                  obs = q ^ ((m == M_FLIP) && msk[k]);
      qn  = qn0 ? 1'b0 : !obs;
      bad = (obs != v[0]);
`ifdef LATCH_EXERCISER_QN_CHECK_EN
      bad = bad || (qn != !v[0]);
`endif
      if (bad) begin
        if (e.err < 15) e.err++;
        if (e.fs == 15) e.fs = k;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_set_n"},   dut_set_n,   1);
    check({tag, "_reset_n"}, dut_reset_n, 1);
    check({tag, "_d"},       dut_d,       0);
    check({tag, "_g"},       dut_g,       0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_done"},    done,        0);
    check({tag, "_pass"},    pass,        0);
    check({tag, "_err"},     err_count,   0);
    check({tag, "_fstep"},   fail_step,   15);
  endtask

  // Monitor: pops one expectation per rising done.
  initial begin : monitor
    bit done_prev, overlap;
    exp_t e;
    done_prev = 1'b0;
    overlap   = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("err_count", err_count, e.err);
          check("fail_step", fail_step, e.fs);
          check("pass",      pass,      e.pass);
          check("run_len",   cyc - e.start_cyc, RUN_LEN);
          check("busy_done_overlap", overlap, 0);
          overlap = 1'b0;
        end
      end
      done_prev = done;
    end
  end

  task automatic run(mode_t m, logic [11:0] msk, bit qn0, bit noise, bit prev_done);
    exp_t e;
    int   n;
    e = predict(m, msk, qn0);
    @(negedge clk);
    if (prev_done) check("done_held", done, 1);
    mode      = m;
    mask      = msk;
    qn_tie0   = qn0;
    run_start = cyc + 1;
    e.start_cyc = run_start;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared",     done, 0);
    n = 0;
    while (!done && n < 4 * RUN_LEN) begin
      if (noise && busy && $urandom_range(0, 5) == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  initial begin
    mode_t rm;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run(M_GOOD, 12'h000, 1'b0, 1'b0, 1'b0);
    run(M_TIE0, 12'h000, 1'b0, 1'b1, 1'b1);
    run(M_TIE1, 12'h000, 1'b0, 1'b0, 1'b1);
    run(M_GIGN, 12'h000, 1'b0, 1'b1, 1'b1);
    run(M_GOOD, 12'h000, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      rm = mode_t'($urandom_range(0, 4));
      run(rm, 12'($urandom), 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end

    // Abort mid-run: everything must snap to reset values, no done afterwards.
    @(negedge clk);
    mode = M_GOOD; qn_tie0 = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (2) @(negedge clk);
    check_reset_vals("abort_hold");
    reset_n = 1'b1;
    repeat (RUN_LEN) @(negedge clk);
    check("abort_no_done", done, 0);
    check("abort_no_busy", busy, 0);

    run(M_GOOD, 12'h000, 1'b0, 1'b1, 1'b0);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
